// File: rtl/glove_letter_encoder.sv
// Debounces a 5-bit glove finger code and hands each stable legal letter to the glyph drawer.
// Optional LETTER_REPEAT_EN: re-issue a held letter every REPEAT_CYCLES while it stays held.
module glove_letter_encoder #(
  parameter int STABLE_CYCLES = 25000000,
  parameter int REPEAT_CYCLES = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [4:0] GPIO_0,
  input  logic       busy,
  output logic [4:0] letter,
  output logic       draw,
  output logic [7:0] letter_cnt
);

  typedef enum logic [2:0] {IDLE, SETTLE, ISSUE, WAIT_DONE, REARM} stateType;

  localparam logic [27:0] STABLE_LAST = 28'(STABLE_CYCLES - 1);
`ifdef LETTER_REPEAT_EN
  localparam logic [27:0] REPEAT_LAST = 28'(REPEAT_CYCLES - 1);
`endif

  stateType    stateReg, stateNext;
  logic [4:0]  syncMeta, syncReg;
  logic [27:0] countReg, countNext;
  logic [4:0]  candReg, candNext;
  logic [4:0]  letterReg, letterNext;
  logic        drawReg, drawNext;
  logic [7:0]  letterCntReg, letterCntNext;

  // Rest plus the five codes the glove cannot form reliably are never issued.
  function automatic logic isLegal(input logic [4:0] code);
    return !(code inside {5'b00000, 5'b00100, 5'b01010, 5'b10110, 5'b11010, 5'b11011});
  endfunction

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      syncMeta     <= '0;
      syncReg      <= '0;
      stateReg     <= IDLE;
      countReg     <= '0;
      candReg      <= '0;
      letterReg    <= '0;
      drawReg      <= 1'b0;
      letterCntReg <= '0;
    end else begin
      syncMeta     <= GPIO_0;
      syncReg      <= syncMeta;
      stateReg     <= stateNext;
      countReg     <= countNext;
      candReg      <= candNext;
      letterReg    <= letterNext;
      drawReg      <= drawNext;
      letterCntReg <= letterCntNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    countNext     = countReg;
    candNext      = candReg;
    letterNext    = letterReg;
    drawNext      = drawReg;
    letterCntNext = letterCntReg;
    case (stateReg)
      IDLE: begin
        if (isLegal(syncReg)) begin
          candNext  = syncReg;
          countNext = '0;
          stateNext = SETTLE;
        end
      end
      SETTLE: begin
        if (syncReg != candReg) begin
          countNext = '0;
          stateNext = IDLE;
        end else if (countReg == STABLE_LAST) begin
          letterNext = candReg;
          drawNext   = 1'b1;
          stateNext  = ISSUE;
        end else begin
          countNext = countReg + 28'd1;
        end
      end
      ISSUE: begin
        // Waits indefinitely for the drawer; the glove input is not looked at here.
        if (busy) begin
          drawNext      = 1'b0;
          letterCntNext = letterCntReg + 8'd1;
          stateNext     = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!busy) begin
          countNext = '0;
          stateNext = REARM;
        end
      end
      REARM: begin
        if (syncReg != letterReg) begin
          stateNext = IDLE;
`ifdef LETTER_REPEAT_EN
        end else if (countReg == REPEAT_LAST) begin
          drawNext  = 1'b1;
          countNext = '0;
          stateNext = ISSUE;
        end else begin
          countNext = countReg + 28'd1;
`endif
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign letter     = letterReg;
  assign draw       = drawReg;
  assign letter_cnt = letterCntReg;

endmodule

// File: tb/tb_glove_letter_encoder.sv
// Scoreboard bench for glove_letter_encoder with a drawer model answering each draw request.
module tb_glove_letter_encoder;
  localparam int STABLE = 8;
  localparam int REPEAT = 20;
  localparam int WINDOW = 195;
`ifdef LETTER_REPEAT_EN
  localparam int HOLD_DRAWS = 7;
`else
  localparam int HOLD_DRAWS = 1;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic [4:0] GPIO_0   = 5'b0;
  logic       busy     = 1'b0;
  logic [4:0] letter;
  logic       draw;
  logic [7:0] letter_cnt;

  glove_letter_encoder #(.STABLE_CYCLES(STABLE), .REPEAT_CYCLES(REPEAT)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .GPIO_0(GPIO_0), .busy(busy),
    .letter(letter), .draw(draw), .letter_cnt(letter_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {logic [4:0] letter; logic [7:0] cnt;} expType;
  expType sbQ[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int drawRises = 0;
  logic drawPrev = 1'b0;
  logic [7:0] expCnt = 8'd0;
  logic [4:0] expLetter = 5'd0;

  always @(posedge CLOCK_50) begin
    cyc      <= cyc + 1;
    drawPrev <= draw;
    if (draw && !drawPrev) drawRises <= drawRises + 1;
  end

  // Drawer: raises busy two cycles after seeing draw, holds it for four cycles.
  initial begin
    forever begin
      @(posedge CLOCK_50); #1;
      if (draw) begin
        repeat (2) @(posedge CLOCK_50);
        #1 busy = 1'b1;
        repeat (4) @(posedge CLOCK_50);
        #1 busy = 1'b0;
      end
    end
  end

  task automatic waitDraw(output int lat);
    lat = 0;
    do begin
      @(negedge CLOCK_50);
      lat++;
    end while (!draw && lat < 100);
    if (!draw) lat = -1;
  endtask

  task automatic waitHandshake(output bit ok);
    int n = 0;
    bit sawBusy;
    while (!busy && n < 50) begin @(negedge CLOCK_50); n++; end
    sawBusy = busy;
    while (busy && n < 100) begin @(negedge CLOCK_50); n++; end
    ok = sawBusy && !busy;
  endtask

  task automatic settle();
    GPIO_0 = 5'b0;
    repeat (40) @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    vectors++; if (draw !== 1'b0) begin miscompares++; $display("FAIL reset_draw: got %b want 0", draw); end
    vectors++; if (letter !== 5'd0) begin miscompares++; $display("FAIL reset_letter: got %b want 00000", letter); end
    vectors++; if (letter_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", letter_cnt); end
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    expCnt = 8'd0;
    @(negedge CLOCK_50);
    $display("reset: draw=%b letter=%b letter_cnt=%0d", draw, letter, letter_cnt);
  endtask

  task automatic test_held_letter(input logic [4:0] code);
    expType e;
    int lat, c0, r0;
    bit ok;
    r0 = drawRises;
    c0 = cyc;
    e.letter = code;
    e.cnt    = expCnt + 8'd1;
    sbQ.push_back(e);
    GPIO_0 = code;
    waitDraw(lat);
    vectors++; if (lat != STABLE + 3) begin miscompares++; $display("FAIL held_latency: got %0d edges want %0d", lat, STABLE + 3); end
    e = sbQ.pop_front();
    vectors++; if (letter !== e.letter) begin miscompares++; $display("FAIL held_letter: got %b want %b", letter, e.letter); end
    waitHandshake(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL held_handshake: busy handshake got %b want 1", ok); end
    vectors++; if (draw !== 1'b0) begin miscompares++; $display("FAIL held_draw_fall: got %b want 0", draw); end
    expCnt = e.cnt;
    vectors++; if (letter_cnt !== expCnt) begin miscompares++; $display("FAIL held_cnt: got %0d want %0d", letter_cnt, expCnt); end
    while (cyc - c0 < WINDOW) @(negedge CLOCK_50);
    vectors++; if (drawRises - r0 != HOLD_DRAWS) begin miscompares++; $display("FAIL held_draw_count: got %0d want %0d", drawRises - r0, HOLD_DRAWS); end
    expCnt = expCnt + 8'(HOLD_DRAWS - 1);
    expLetter = code;
    vectors++; if (letter_cnt !== expCnt) begin miscompares++; $display("FAIL held_cnt_end: got %0d want %0d", letter_cnt, expCnt); end
    vectors++; if (letter !== code) begin miscompares++; $display("FAIL held_letter_end: got %b want %b", letter, code); end
    $display("held %b: latency=%0d draws=%0d letter_cnt=%0d", code, lat, drawRises - r0, letter_cnt);
    settle();
  endtask

  task automatic test_glitch();
    int r0 = drawRises;
    GPIO_0 = 5'b00010;
    repeat (5) @(negedge CLOCK_50);
    GPIO_0 = 5'b00000;
    repeat (30) @(negedge CLOCK_50);
    vectors++; if (drawRises != r0) begin miscompares++; $display("FAIL glitch_draws: got %0d want 0", drawRises - r0); end
    vectors++; if (letter !== expLetter) begin miscompares++; $display("FAIL glitch_letter: got %b want %b", letter, expLetter); end
    vectors++; if (letter_cnt !== expCnt) begin miscompares++; $display("FAIL glitch_cnt: got %0d want %0d", letter_cnt, expCnt); end
    $display("glitch 00010x5: draws=%0d letter=%b letter_cnt=%0d", drawRises - r0, letter, letter_cnt);
  endtask

  task automatic test_illegal();
    logic [4:0] codes [6] = '{5'b00000, 5'b00100, 5'b01010, 5'b10110, 5'b11010, 5'b11011};
    for (int i = 0; i < 6; i++) begin
      int r0 = drawRises;
      GPIO_0 = codes[i];
      repeat ((codes[i] == 5'b01010) ? 100 : 30) @(negedge CLOCK_50);
      vectors++; if (drawRises != r0 || draw !== 1'b0) begin miscompares++; $display("FAIL illegal_%b: draws got %0d want 0", codes[i], drawRises - r0); end
      GPIO_0 = 5'b0;
      repeat (3) @(negedge CLOCK_50);
      $display("illegal %b: draws=%0d", codes[i], drawRises - r0);
    end
    vectors++; if (letter_cnt !== expCnt) begin miscompares++; $display("FAIL illegal_cnt: got %0d want %0d", letter_cnt, expCnt); end
  endtask

  task automatic test_reset_mid();
    expType e;
    int lat;
    bit ok;
    e.letter = 5'b00001;
    e.cnt    = expCnt + 8'd1;
    sbQ.push_back(e);
    GPIO_0 = 5'b00001;
    waitDraw(lat);
    e = sbQ.pop_front();
    vectors++; if (letter !== e.letter) begin miscompares++; $display("FAIL rmid_letter: got %b want %b", letter, e.letter); end
    repeat (4) @(negedge CLOCK_50);
    vectors++; if (letter_cnt !== e.cnt) begin miscompares++; $display("FAIL rmid_cnt_pre: got %0d want %0d", letter_cnt, e.cnt); end
    #2 resetn = 1'b0;
    #1;
    vectors++; if (draw !== 1'b0) begin miscompares++; $display("FAIL rmid_draw: got %b want 0", draw); end
    vectors++; if (letter !== 5'd0) begin miscompares++; $display("FAIL rmid_letter_clr: got %b want 00000", letter); end
    vectors++; if (letter_cnt !== 8'd0) begin miscompares++; $display("FAIL rmid_cnt_clr: got %0d want 0", letter_cnt); end
    @(negedge CLOCK_50);
    resetn = 1'b1;
    expCnt = 8'd0;
    e.letter = 5'b00001;
    e.cnt    = 8'd1;
    sbQ.push_back(e);
    waitDraw(lat);
    vectors++; if (lat != STABLE + 3) begin miscompares++; $display("FAIL rmid_latency: got %0d edges want %0d", lat, STABLE + 3); end
    e = sbQ.pop_front();
    vectors++; if (letter !== e.letter) begin miscompares++; $display("FAIL rmid_reissue: got %b want %b", letter, e.letter); end
    waitHandshake(ok);
    expCnt = e.cnt;
    vectors++; if (!ok || letter_cnt !== expCnt) begin miscompares++; $display("FAIL rmid_cnt_post: got %0d (handshake %b) want %0d", letter_cnt, ok, expCnt); end
    $display("reset mid WAIT_DONE: reissue latency=%0d letter_cnt=%0d", lat, letter_cnt);
    settle();
  endtask

  task automatic test_wrap();
    @(negedge CLOCK_50);
    resetn = 1'b0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    expCnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      expType e;
      int lat;
      bit ok;
      e.letter = (i % 2 == 0) ? 5'b00001 : 5'b00010;
      e.cnt    = expCnt + 8'd1;
      sbQ.push_back(e);
      GPIO_0 = e.letter;
      waitDraw(lat);
      e = sbQ.pop_front();
      vectors++; if (lat != STABLE + 3 || letter !== e.letter) begin miscompares++; $display("FAIL wrap_issue_%0d: got letter %b after %0d edges want %b after %0d", i, letter, lat, e.letter, STABLE + 3); end
      waitHandshake(ok);
      expCnt = e.cnt;
      vectors++; if (!ok || letter_cnt !== expCnt) begin miscompares++; $display("FAIL wrap_cnt_%0d: got %0d (handshake %b) want %0d", i, letter_cnt, ok, expCnt); end
      if (i % 32 == 31 || i >= 254) $display("wrap letter %0d: letter=%b letter_cnt=%0d", i, letter, letter_cnt);
      GPIO_0 = 5'b0;
      repeat (4) @(negedge CLOCK_50);
    end
    vectors++; if (letter_cnt !== 8'd0) begin miscompares++; $display("FAIL wrap_final: got %0d want 0", letter_cnt); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_held_letter(5'b00001);
    test_glitch();
    test_illegal();
    test_held_letter(5'b00011);
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
